// File: rtl/overdrive_pipe_if.sv
// Sample-stream bundle for the overdrive stage: input sample/gain/mode strobe,
// processed output strobe, clip metering and the live gain for observation.
interface overdrive_pipe_if #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 16
);
    // in_valid qualifies signal_in/gain_tgt/mode for one cycle and there is no
    // ready: every valid cycle is accepted. out_valid pulses once per accepted
    // sample, three edges after the capturing edge, in order.
    logic                     in_valid;
    logic signed [DATA_W-1:0] signal_in;
    logic        [GAIN_W-1:0] gain_tgt;
    logic        [1:0]        mode;
    logic                     clr_cnt;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  signal_out;
    logic                     clipped;
    logic        [CNT_W-1:0]  clip_count;
    logic        [GAIN_W-1:0] gain_cur;

    modport master (
        output in_valid, signal_in, gain_tgt, mode, clr_cnt,
        input  out_valid, signal_out, clipped, clip_count, gain_cur
    );

    modport slave (
        input  in_valid, signal_in, gain_tgt, mode, clr_cnt,
        output out_valid, signal_out, clipped, clip_count, gain_cur
    );
endinterface

// File: rtl/overdrive_pipe.sv
// Pipelined overdrive: ramped gain, then bypass / hard / soft-knee clip curve,
// with a per-sample clip flag and a saturating clip counter.
module overdrive_pipe #(
    parameter int DATA_W     = 16,
    parameter int GAIN_W     = 16,
    parameter int GAIN_FRAC  = 4,
    parameter int LEVEL_BITS = 12,
    parameter int OUT_W      = 32,
    parameter int RAMP_STEP  = 1,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    overdrive_pipe_if.slave bus
);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int MUL_W  = (PROD_W > OUT_W) ? PROD_W : OUT_W;
    localparam int DIFF_W = GAIN_W + 1;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(64'd1 << GAIN_FRAC);
    localparam logic [GAIN_W-1:0] STEP_G     = GAIN_W'(RAMP_STEP);
    localparam logic [DIFF_W-1:0] STEP_D     = DIFF_W'(RAMP_STEP);

    localparam logic signed [OUT_W-1:0] LVL_P =
        {{(OUT_W-LEVEL_BITS){1'b0}}, {LEVEL_BITS{1'b1}}};
    localparam logic signed [OUT_W-1:0] LVL_N = ~LVL_P;
    localparam logic signed [OUT_W-1:0] LVL_K =
        {{(OUT_W-LEVEL_BITS){1'b0}}, 1'b1, {(LEVEL_BITS-1){1'b0}}};

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_SOFT   = 2'd2;

    // Gain ramp state
    logic        [GAIN_W-1:0] r_gain_cur;
    logic signed [DIFF_W-1:0] w_diff;
    logic        [DIFF_W-1:0] w_abs;
    logic        [GAIN_W-1:0] w_gain_nxt;

    // Stage 1: captured sample
    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_s1_x;
    logic        [GAIN_W-1:0] r_s1_gain;
    logic        [1:0]        r_s1_mode;

    // Stage 2: raw product
    logic                     r_s2_valid;
    logic signed [MUL_W-1:0]  r_s2_prod;
    logic        [1:0]        r_s2_mode;

    // Stage 3: scaled sample y
    logic                     r_s3_valid;
    logic signed [OUT_W-1:0]  r_s3_y;
    logic        [1:0]        r_s3_mode;

    // Output stage
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out;
    logic                     r_clipped;
    logic        [CNT_W-1:0]  r_clip_count;

    logic signed [MUL_W-1:0]  w_x_ext;
    logic signed [MUL_W-1:0]  w_g_ext;
    logic signed [MUL_W-1:0]  w_prod;
    logic signed [OUT_W-1:0]  w_y;
    logic signed [OUT_W-1:0]  w_soft;
    logic signed [OUT_W-1:0]  w_curve;
    logic                     w_clip;

    function automatic logic signed [OUT_W-1:0] f_clamp(input logic signed [OUT_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        r = v;
        if (v > LVL_P) begin
            r = LVL_P;
        end else if (v < LVL_N) begin
            r = LVL_N;
        end
        f_clamp = r;
    endfunction

    assign w_diff = $signed({1'b0, bus.gain_tgt}) - $signed({1'b0, r_gain_cur});
    assign w_abs  = w_diff[DIFF_W-1] ? $unsigned(-w_diff) : $unsigned(w_diff);

    // Close enough (or no ramping) snaps to target; otherwise step toward it.
    always_comb begin
        w_gain_nxt = r_gain_cur;
        if ((RAMP_STEP == 0) || (w_abs <= STEP_D)) begin
            w_gain_nxt = bus.gain_tgt;
        end else if (w_diff[DIFF_W-1]) begin
            w_gain_nxt = r_gain_cur - STEP_G;
        end else begin
            w_gain_nxt = r_gain_cur + STEP_G;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain_cur <= GAIN_UNITY;
        end else if (bus.in_valid) begin
            r_gain_cur <= w_gain_nxt;
        end
    end

    // Stage 1 takes the gain in force before this sample's ramp update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_gain  <= '0;
            r_s1_mode  <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            r_s1_x     <= bus.signal_in;
            r_s1_gain  <= r_gain_cur;
            r_s1_mode  <= bus.mode;
        end
    end

    // Unsigned gain is zero-extended so a signed multiply gives the right sign.
    assign w_x_ext = {{(MUL_W-DATA_W){r_s1_x[DATA_W-1]}}, r_s1_x};
    assign w_g_ext = {{(MUL_W-GAIN_W){1'b0}}, r_s1_gain};
    assign w_prod  = w_x_ext * w_g_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_mode  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_prod;
            r_s2_mode  <= r_s1_mode;
        end
    end

    // Arithmetic shift floors; the result always fits OUT_W so truncation is exact.
    assign w_y = OUT_W'(r_s2_prod >>> GAIN_FRAC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_y     <= '0;
            r_s3_mode  <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_y     <= w_y;
            r_s3_mode  <= r_s2_mode;
        end
    end

    // Soft knee: slope 1/4 beyond +/-K, then the same hard limits apply.
    always_comb begin
        w_soft = r_s3_y;
        if (r_s3_y > LVL_K) begin
            w_soft = LVL_K + ((r_s3_y - LVL_K) >>> 2);
        end else if (r_s3_y < -LVL_K) begin
            w_soft = -LVL_K - ((-r_s3_y - LVL_K) >>> 2);
        end
    end

    always_comb begin
        w_curve = f_clamp(r_s3_y);
        if (r_s3_mode == MODE_BYPASS) begin
            w_curve = r_s3_y;
        end else if (r_s3_mode == MODE_SOFT) begin
            w_curve = f_clamp(w_soft);
        end
    end

    assign w_clip = (w_curve != r_s3_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_clipped   <= 1'b0;
        end else begin
            r_out_valid <= r_s3_valid;
            r_out       <= w_curve;
            r_clipped   <= r_s3_valid & w_clip;
        end
    end

    // Counts presented clipped outputs; a clear on the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_count <= '0;
        end else if (bus.clr_cnt) begin
            r_clip_count <= '0;
        end else if (r_out_valid && r_clipped && (r_clip_count != {CNT_W{1'b1}})) begin
            r_clip_count <= r_clip_count + CNT_W'(1);
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.signal_out = r_out;
    assign bus.clipped    = r_clipped;
    assign bus.clip_count = r_clip_count;
    assign bus.gain_cur   = r_gain_cur;
endmodule

// File: tb/tb_overdrive_pipe.sv
// Directed bench for overdrive_pipe: three instances (instant gain, ramped gain,
// 2-bit counter) share one stimulus stream; instance a is scored from a queue.
module tb_overdrive_pipe;
  localparam int OUT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic signed [15:0] signal_in;
  logic [15:0] gain_tgt;
  logic [1:0] mode;
  logic clr_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int n_seen = 0;
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] mon_e;
  int ramp_out[5] = '{100, 125, 150, 175, 175};
  int ramp_gain[5] = '{20, 24, 28, 28, 28};

  // clock / reset
  always #5 clk = ~clk;

  overdrive_pipe_if #(.DATA_W(16), .GAIN_W(16), .OUT_W(32), .CNT_W(16)) if_a ();
  overdrive_pipe_if #(.DATA_W(16), .GAIN_W(16), .OUT_W(32), .CNT_W(16)) if_b ();
  overdrive_pipe_if #(.DATA_W(16), .GAIN_W(16), .OUT_W(32), .CNT_W(2)) if_c ();

  assign if_a.in_valid = in_valid;
  assign if_a.signal_in = signal_in;
  assign if_a.gain_tgt = gain_tgt;
  assign if_a.mode = mode;
  assign if_a.clr_cnt = clr_cnt;
  assign if_b.in_valid = in_valid;
  assign if_b.signal_in = signal_in;
  assign if_b.gain_tgt = gain_tgt;
  assign if_b.mode = mode;
  assign if_b.clr_cnt = clr_cnt;
  assign if_c.in_valid = in_valid;
  assign if_c.signal_in = signal_in;
  assign if_c.gain_tgt = gain_tgt;
  assign if_c.mode = mode;
  assign if_c.clr_cnt = clr_cnt;

  overdrive_pipe #(.RAMP_STEP(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  overdrive_pipe #(.RAMP_STEP(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  overdrive_pipe #(.RAMP_STEP(0), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic send(input logic signed [15:0] x, input logic [15:0] g, input logic [1:0] m);
    in_valid = 1'b1;
    signal_in = x;
    gain_tgt = g;
    mode = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_a(input logic signed [31:0] v, input logic c);
    exp_q.push_back({c, v});
    if (c) exp_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard for instance a
  always @(negedge clk) begin
    if (if_a.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("a_extra", if_a.out_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("a_out", $signed(if_a.signal_out), $signed(mon_e[OUT_W-1:0]));
        check("a_clip", if_a.clipped, mon_e[OUT_W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    signal_in = '0;
    gain_tgt = 16'd16;
    mode = 2'd0;
    clr_cnt = 1'b0;
    idle(3);
    check("rst_valid_a", if_a.out_valid, 0);
    check("rst_out_a", $signed(if_a.signal_out), 0);
    check("rst_clip_a", if_a.clipped, 0);
    check("rst_cnt_a", if_a.clip_count, 0);
    check("rst_gain_a", if_a.gain_cur, 16);
    check("rst_gain_b", if_b.gain_cur, 16);
    check("rst_valid_c", if_c.out_valid, 0);
    rst_n = 1'b1;
    idle(1);

    // unity gain, latency of three edges, one-cycle strobe
    expect_a(1000, 0); send(1000, 16'd16, 2'd1);
    idle(2); check("lat_k2", if_a.out_valid, 0);
    idle(1); check("lat_k3", if_a.out_valid, 1);
    idle(1); check("lat_k4", if_a.out_valid, 0);

    // hard-clip limits at unity gain
    expect_a(4095, 0);  send(4095, 16'd16, 2'd1);
    expect_a(4095, 1);  send(4096, 16'd16, 2'd1);
    expect_a(-4096, 0); send(-4096, 16'd16, 2'd1);
    expect_a(-4096, 1); send(-4097, 16'd16, 2'd1);

    // gain 0.5, floor rounding (first sample still runs at gain 16)
    expect_a(0, 0);  send(0, 16'd8, 2'd0);
    expect_a(-1, 0); send(-1, 16'd8, 2'd0);
    expect_a(-9, 0); send(-17, 16'd8, 2'd0);
    expect_a(8, 0);  send(17, 16'd8, 2'd0);

    // hard clip at gain 8.0
    expect_a(0, 0);     send(0, 16'd128, 2'd1);
    expect_a(4095, 1);  send(1000, 16'd128, 2'd1);
    expect_a(-4096, 1); send(-1000, 16'd128, 2'd1);
    idle(6);
    check("cnt_hard_a", if_a.clip_count, exp_cnt);
    check("cnt_hard_c", if_c.clip_count, (exp_cnt > 3) ? 3 : exp_cnt);

    // soft knee, then reserved mode behaves as hard clip
    expect_a(2136, 1);  send(300, 16'd128, 2'd2);
    expect_a(3536, 1);  send(1000, 16'd128, 2'd2);
    expect_a(1600, 0);  send(200, 16'd128, 2'd2);
    expect_a(-2136, 1); send(-300, 16'd128, 2'd2);
    expect_a(4095, 1);  send(2000, 16'd128, 2'd2);
    expect_a(2048, 0);  send(256, 16'd128, 2'd2);
    expect_a(-2048, 0); send(-256, 16'd128, 2'd2);
    expect_a(-2050, 1); send(-257, 16'd128, 2'd2);
    expect_a(4095, 1);  send(1000, 16'd128, 2'd3);

    // bypass extremes at maximum gain
    expect_a(0, 0);          send(0, 16'hFFFF, 2'd0);
    expect_a(-134215680, 0); send(-32768, 16'hFFFF, 2'd0);
    expect_a(134211584, 0);  send(32767, 16'hFFFF, 2'd0);
    idle(6);
    check("cnt_soft_a", if_a.clip_count, exp_cnt);
    check("cnt_soft_c", if_c.clip_count, (exp_cnt > 3) ? 3 : exp_cnt);

    // clear on the same cycle as a clipped output
    expect_a(4095, 1); send(100, 16'hFFFF, 2'd1);
    idle(3);
    check("cnt_hold_a", if_a.clip_count, exp_cnt - 1);
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    check("cnt_clr_a", if_a.clip_count, 0);
    check("cnt_clr_c", if_c.clip_count, 0);
    exp_cnt = 0;
    expect_a(-4096, 1); send(-100, 16'hFFFF, 2'd1);
    idle(6);
    check("cnt_after_a", if_a.clip_count, exp_cnt);
    check("cnt_after_c", if_c.clip_count, exp_cnt);

    // asynchronous reset with samples in flight
    expect_a(4095, 0); send(1, 16'hFFFF, 2'd1);
    send(2, 16'hFFFF, 2'd1);
    send(3, 16'hFFFF, 2'd1);
    idle(1);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("arst_valid_a", if_a.out_valid, 0);
    check("arst_out_a", $signed(if_a.signal_out), 0);
    check("arst_cnt_a", if_a.clip_count, 0);
    check("arst_gain_a", if_a.gain_cur, 16);
    check("arst_valid_b", if_b.out_valid, 0);
    idle(2);
    rst_n = 1'b1;
    exp_cnt = 0;
    n_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_a.out_valid === 1'b1) n_seen++;
    end
    check("arst_none", n_seen, 0);

    // gain ramp on instance b, idle gaps and a mid-ramp mode change
    for (int i = 0; i < 5; i++) begin
      expect_a((i == 0) ? 100 : 175, 0);
      send(100, 16'd28, (i == 2) ? 2'd1 : 2'd0);
      check("ramp_gain", if_b.gain_cur, ramp_gain[i]);
      idle(3);
      check("ramp_valid", if_b.out_valid, 1);
      check("ramp_out", $signed(if_b.signal_out), ramp_out[i]);
      idle(2);
      check("ramp_idle_gain", if_b.gain_cur, ramp_gain[i]);
    end

    // counter saturation on the 2-bit instance
    expect_a(0, 0); send(0, 16'hFFFF, 2'd1);
    for (int i = 0; i < 5; i++) begin
      expect_a(4095, 1); send(1000, 16'hFFFF, 2'd1);
    end
    idle(6);
    check("sat_a", if_a.clip_count, exp_cnt);
    check("sat_c", if_c.clip_count, 3);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
